// File: rtl/seg_display_arbiter_if.sv
// seg_display_arbiter_if: bus between requesters and the display arbiter.
//   req     : per-requester update request (level)
//   hex_in  : requester i value at [16*i +: 16]
//   gnt     : one-hot, one-cycle grant acknowledge
//   owner   : index of the last granted requester
//   busy    : high from grant until the hold period ends
//   hex     : value presented to the display controller
//   load    : one-cycle load strobe to the display controller
//   mux_clk : digit-scan clock to the display controller
// master = requester side, slave = arbiter side.
interface seg_display_arbiter_if #(parameter int NUM_REQ = 2);
    localparam int OW = $clog2(NUM_REQ);
    logic [NUM_REQ-1:0]    req;
    logic [16*NUM_REQ-1:0] hex_in;
    logic [NUM_REQ-1:0]    gnt;
    logic [OW-1:0]         owner;
    logic                  busy;
    logic [15:0]           hex;
    logic                  load;
    logic                  mux_clk;
    modport master (output req, hex_in, input gnt, owner, busy, hex, load, mux_clk);
    modport slave  (input req, hex_in, output gnt, owner, busy, hex, load, mux_clk);
endinterface

// File: rtl/seg_display_arbiter.sv
// seg_display_arbiter: shares a 4-digit seven-segment display controller
// between NUM_REQ requesters and generates its digit-scan clock.
//   i_clk   : system clock, all logic on posedge
//   i_rst_n : asynchronous active-low reset
//   bus     : seg_display_arbiter_if.slave (req/hex_in in; gnt/owner/busy/hex/load/mux_clk out)
// Build option: define SEG_ARB_FIXED_PRIO_EN for strict fixed priority
// (lowest asserted index wins); otherwise round-robin arbitration.
module seg_display_arbiter #(
    parameter int NUM_REQ  = 2,
    parameter int MUX_DIV  = 4,
    parameter int MIN_HOLD = 8
) (
    input logic i_clk,
    input logic i_rst_n,
    seg_display_arbiter_if.slave bus
);
    localparam int OW = $clog2(NUM_REQ);
    localparam int DW = MUX_DIV > 1 ? $clog2(MUX_DIV) : 1;
    localparam int HW = MIN_HOLD > 0 ? $clog2(MIN_HOLD + 1) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

    state_t             r_state;
    logic [NUM_REQ-1:0] r_gnt;
    logic [OW-1:0]      r_owner;
    logic [OW-1:0]      w_win;
    logic               r_busy;
    logic               r_load;
    logic               r_mux;
    logic [15:0]        r_hex;
    logic [DW-1:0]      r_div;
    logic [HW-1:0]      r_hold;

    // Free-running scan clock divider, independent of arbitration.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_div <= '0;
            r_mux <= 1'b0;
        end else if (r_div == DW'(MUX_DIV - 1)) begin
            r_div <= '0;
            r_mux <= ~r_mux;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

`ifdef SEG_ARB_FIXED_PRIO_EN
    // Descending scan so the lowest asserted index is the last (winning) assignment.
    always_comb begin
        w_win = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--)
            if (bus.req[OW'(k)]) w_win = OW'(k);
    end
`else
    logic [OW-1:0] r_ptr;
    // Descending scan from the pointer so the nearest asserted index at or after it wins.
    always_comb begin
        w_win = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--)
            if (bus.req[OW'((int'(r_ptr) + k) % NUM_REQ)]) w_win = OW'((int'(r_ptr) + k) % NUM_REQ);
    end
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_owner <= '0;
            r_busy  <= 1'b0;
            r_load  <= 1'b0;
            r_hex   <= '0;
            r_hold  <= '0;
`ifndef SEG_ARB_FIXED_PRIO_EN
            r_ptr   <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: if (|bus.req) begin
                    r_hex   <= bus.hex_in[16*int'(w_win) +: 16];
                    r_owner <= w_win;
                    r_gnt   <= NUM_REQ'(1) << w_win;
                    r_busy  <= 1'b1;
                    r_state <= SETUP;
                end
                // HEX has been stable for one cycle here, so the LOAD edge is safe.
                SETUP: begin
                    r_gnt   <= '0;
                    r_load  <= 1'b1;
                    r_state <= STROBE;
                end
                STROBE: begin
                    r_load <= 1'b0;
`ifndef SEG_ARB_FIXED_PRIO_EN
                    r_ptr  <= OW'((int'(r_owner) + 1) % NUM_REQ);
`endif
                    if (MIN_HOLD == 0) begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_hold  <= HW'(1);
                        r_state <= HOLD;
                    end
                end
                HOLD: if (r_hold == HW'(MIN_HOLD)) begin
                    r_busy  <= 1'b0;
                    r_hold  <= '0;
                    r_state <= IDLE;
                end else begin
                    r_hold <= r_hold + 1'b1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.gnt     = r_gnt;
    assign bus.owner   = r_owner;
    assign bus.busy    = r_busy;
    assign bus.hex     = r_hex;
    assign bus.load    = r_load;
    assign bus.mux_clk = r_mux;
endmodule

// File: tb/tb_seg_display_arbiter.sv
// tb_seg_display_arbiter: checks two arbiter builds (MIN_HOLD=8/MUX_DIV=4 and
// MIN_HOLD=0/MUX_DIV=1) against a transaction-level timing model.
module tb_seg_display_arbiter;
    localparam int N = 2;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [1:0] req_drv = '0;
    logic [31:0] hexin_drv = '0;
    always #5 clk = ~clk;

    seg_display_arbiter_if #(.NUM_REQ(N)) bus0();
    seg_display_arbiter_if #(.NUM_REQ(N)) bus1();
    assign bus0.req = req_drv;
    assign bus0.hex_in = hexin_drv;
    assign bus1.req = req_drv;
    assign bus1.hex_in = hexin_drv;

    seg_display_arbiter #(.NUM_REQ(N), .MUX_DIV(4), .MIN_HOLD(8)) dut0 (.i_clk(clk), .i_rst_n(rst_n), .bus(bus0));
    seg_display_arbiter #(.NUM_REQ(N), .MUX_DIV(1), .MIN_HOLD(0)) dut1 (.i_clk(clk), .i_rst_n(rst_n), .bus(bus1));

    int passed = 0;
    int total = 0;
    int n = 0;
    int mh[2] = '{8, 0};
    int md[2] = '{4, 1};
    int g[2] = '{-100, -100};
    int ptr[2] = '{0, 0};
    int win[2] = '{0, 0};
    logic [15:0] hexm[2] = '{16'h0, 16'h0};
    logic reached;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic int pick(int d, logic [1:0] r);
`ifdef SEG_ARB_FIXED_PRIO_EN
        for (int k = 0; k < N; k++) if (r[k]) return k;
`else
        for (int k = 0; k < N; k++) if (r[(ptr[d] + k) % N]) return (ptr[d] + k) % N;
`endif
        return 0;
    endfunction

    // A grant at edge g implies LOAD at g+1, idle after g+2+hold, next sample at g+3+hold.
    task automatic model_edge(int d);
        if (n >= g[d] + 3 + mh[d] && req_drv != 0) begin
            int w = pick(d, req_drv);
            g[d] = n;
            win[d] = w;
            hexm[d] = hexin_drv[16*w +: 16];
            ptr[d] = (w + 1) % N;
        end
    endtask

    task automatic check_dut(int d, logic [1:0] gnt, logic owner, logic busy, logic [15:0] hex, logic load, logic mux);
        chk($sformatf("d%0d n%0d gnt", d, n), gnt, (n == g[d]) ? (32'd1 << win[d]) : 32'd0);
        chk($sformatf("d%0d n%0d owner", d, n), owner, win[d]);
        chk($sformatf("d%0d n%0d busy", d, n), busy, (n >= g[d] && n <= g[d] + 1 + mh[d]) ? 1 : 0);
        chk($sformatf("d%0d n%0d hex", d, n), hex, hexm[d]);
        chk($sformatf("d%0d n%0d load", d, n), load, (n == g[d] + 1) ? 1 : 0);
        chk($sformatf("d%0d n%0d mux", d, n), mux, (n / md[d]) % 2);
    endtask

    task automatic tick();
        @(posedge clk);
        n++;
        model_edge(0);
        model_edge(1);
        #1;
        check_dut(0, bus0.gnt, bus0.owner, bus0.busy, bus0.hex, bus0.load, bus0.mux_clk);
        check_dut(1, bus1.gnt, bus1.owner, bus1.busy, bus1.hex, bus1.load, bus1.mux_clk);
    endtask

    task automatic chk_zero(string tag);
        chk({tag, " d0 gnt"}, bus0.gnt, 0);
        chk({tag, " d0 owner"}, bus0.owner, 0);
        chk({tag, " d0 busy"}, bus0.busy, 0);
        chk({tag, " d0 hex"}, bus0.hex, 0);
        chk({tag, " d0 load"}, bus0.load, 0);
        chk({tag, " d0 mux"}, bus0.mux_clk, 0);
        chk({tag, " d1 gnt"}, bus1.gnt, 0);
        chk({tag, " d1 hex"}, bus1.hex, 0);
        chk({tag, " d1 load"}, bus1.load, 0);
        chk({tag, " d1 mux"}, bus1.mux_clk, 0);
    endtask

    initial begin
        repeat (10) @(posedge clk);
        #1 chk_zero("reset");
        #4 rst_n = 1'b1;
        n = 0;
        repeat (12) tick();
        // single request from requester 0
        req_drv = 2'b01;
        hexin_drv = {16'h0000, 16'hBEEF};
        tick();
        chk("single gnt", bus0.gnt, 2'b01);
        chk("single hex", bus0.hex, 16'hBEEF);
        req_drv = 2'b00;
        tick();
        chk("single load", bus0.load, 1);
        repeat (14) tick();
        // contention
        req_drv = 2'b11;
        hexin_drv = {16'h2222, 16'h1111};
        repeat (45) tick();
        req_drv = 2'b00;
        repeat (12) tick();
        // short request during hold
        req_drv = 2'b01;
        hexin_drv = {16'h3333, 16'h4444};
        tick();
        req_drv = 2'b00;
        repeat (3) tick();
        req_drv = 2'b10;
        repeat (2) tick();
        req_drv = 2'b00;
        repeat (10) tick();
        chk("short hex kept", bus0.hex, 16'h4444);
        chk("short owner", bus0.owner, 0);
        // randomized traffic
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                req_drv = 2'($urandom_range(0, 3));
                hexin_drv = $urandom();
            end
            tick();
        end
        req_drv = 2'b00;
        repeat (12) tick();
        // reset during STROBE
        req_drv = 2'b01;
        hexin_drv = {16'h5555, 16'hA5A5};
        reached = 1'b0;
        for (int i = 0; i < 20 && !reached; i++) begin
            tick();
            if (n == g[0] + 1) reached = 1'b1;
        end
        chk("strobe reached", reached, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("midreset load", bus0.load, 0);
        chk("midreset hex", bus0.hex, 0);
        chk("midreset busy", bus0.busy, 0);
        req_drv = 2'b10;
        repeat (3) @(posedge clk);
        #1 chk_zero("held reset");
        #4 rst_n = 1'b1;
        n = 0;
        g = '{-100, -100};
        ptr = '{0, 0};
        win = '{0, 0};
        hexm = '{16'h0, 16'h0};
        tick();
        chk("post reset gnt", bus0.gnt, 2'b10);
        chk("post reset hex", bus0.hex, 16'h5555);
        req_drv = 2'b00;
        repeat (15) tick();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
